// File: rtl/mnist_img_loader.sv
// Frame loader for a digit classifier. It receives a sync byte, IMG_SIZE pixel bytes and an
// 8-bit additive checksum, starts the accelerator, and returns an ASCII digit or a NAK byte.
module mnist_pix_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

module mnist_img_loader #(
  parameter int          IMG_SIZE    = 784,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [IMG_SIZE*8-1:0] img_data,
  output logic                  accel_start,
  input  logic                  accel_done,
  input  logic [3:0]            pred_digit,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_err
);
  localparam int CW = $clog2(IMG_SIZE + 1);
  localparam int GW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, RECV, CSUM, START, WAIT_DONE, SEND} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          err_q, err_d;
  logic          prev_done_q, prev_done_d;
  logic          wr_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    gap_d       = gap_q;
    tx_data_d   = tx_data_q;
    err_d       = err_q;
    prev_done_d = accel_done;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = RECV;
          cnt_d   = '0;
          sum_d   = '0;
          gap_d   = '0;
        end
      end
      RECV, CSUM: begin
        // A byte arriving on the would-be timeout cycle wins over the timeout.
        if (rx_valid) begin
          gap_d = '0;
          if (state_q == RECV) begin
            wr_en = 1'b1;
            sum_d = sum_q + rx_data;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(IMG_SIZE - 1)) state_d = CSUM;
          end else if (rx_data == sum_q) begin
            state_d = START;
          end else begin
            tx_data_d = NAK_BYTE;
            err_d     = 1'b1;
            state_d   = SEND;
          end
        end else if (gap_q == GW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (accel_done && !prev_done_q) begin
          tx_data_d = 8'h30 + {4'h0, pred_digit};
          state_d   = SEND;
        end
      end
      SEND: if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      gap_q       <= '0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
      prev_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      gap_q       <= gap_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
      prev_done_q <= prev_done_d;
    end
  end

  // One byte register per pixel, enabled only when the counter addresses it.
  for (genvar i = 0; i < IMG_SIZE; i++) begin : g_pix
    mnist_pix_reg u_pix (
      .clk (clk),
      .rst (rst),
      .we  (wr_en && cnt_q == CW'(i)),
      .d   (rx_data),
      .q   (img_data[i*8 +: 8])
    );
  end

  assign accel_start = (state_q == START);
  assign tx_valid    = (state_q == SEND);
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = err_q;
endmodule

// File: doc/mnist_img_loader.md
MNIST_IMG_LOADER -- requirements
Module: mnist_img_loader

Interface
REQ-001 Parameter IMG_SIZE, default 784: number of pixel bytes per frame.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-003 Parameter TIMEOUT_CYC, default 1000000: maximum idle cycles between bytes inside a frame.
REQ-004 Parameter NAK_BYTE, default 8'hEE: response byte for a rejected frame.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-007 rx_data  in  8  received byte from the serial receiver.
REQ-008 rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle; no backpressure.
REQ-009 img_data  out  IMG_SIZE*8  packed image; pixel i occupies bits [i*8+7:i*8].
REQ-010 accel_start  out  1  one-cycle start pulse to the accelerator.
REQ-011 accel_done  in  1  accelerator completion level.
REQ-012 pred_digit  in  4  accelerator result; valid while accel_done=1.
REQ-013 tx_data  out  8  response byte.
REQ-014 tx_valid  out  1  response valid; held until accepted.
REQ-015 tx_ready  in  1  the transmitter accepts tx_data when tx_valid=1 and tx_ready=1 in the same cycle.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 frame_err  out  1  sticky flag; set on a checksum mismatch or timeout; cleared only by reset.

Function
REQ-018 States: IDLE, RECV, CSUM, START, WAIT_DONE, SEND.
REQ-019 IDLE: rx_valid with rx_data==SYNC_BYTE -> RECV with byte counter=0, 8-bit sum=0, gap counter=0; all other bytes are ignored.
REQ-020 RECV, on each rx_valid:
- write rx_data to pixel[counter];
- sum = (sum + rx_data) mod 256;
- counter++;
- on the write of pixel IMG_SIZE-1 -> CSUM.
REQ-021 A SYNC_BYTE value arriving in RECV is ordinary pixel data and does not restart the frame.
REQ-022 CSUM: the next rx_valid byte is compared with sum.
- Equal -> START.
- Unequal -> tx_data=NAK_BYTE, frame_err=1, -> SEND.
REQ-023 START lasts exactly one cycle with accel_start=1, then -> WAIT_DONE; accel_start=0 in every other state.
REQ-024 WAIT_DONE: on the first cycle where accel_done=1 and the registered previous accel_done=0 (rising edge):
- latch tx_data = 8'h30 + pred_digit (ASCII digit);
- -> SEND.
REQ-025 A stale accel_done already high on entry to WAIT_DONE does not complete the wait; only a rising edge does.
REQ-026 SEND: tx_valid=1 and tx_data stable until the handshake cycle; the cycle after the handshake is IDLE with tx_valid=0.
REQ-027 Gap counter (RECV and CSUM only):
- increments on every cycle without rx_valid;
- resets to 0 on rx_valid;
- on reaching TIMEOUT_CYC -> IDLE, frame_err=1, no response byte.
REQ-028 If rx_valid occurs in the same cycle the gap counter reaches TIMEOUT_CYC, the byte is accepted and no timeout occurs.
REQ-029 rx_valid in START, WAIT_DONE or SEND is dropped; img_data, counter and sum are unchanged.
REQ-030 img_data changes only on RECV writes; it holds the last frame, so it is stable from START through SEND.
REQ-031 A rejected or timed-out frame leaves partial pixels in img_data; no accel_start is issued for that frame.
REQ-032 Latency: accel_start is asserted the cycle after the checksum byte's rx_valid.
REQ-033 Latency: tx_valid rises the cycle after the accel_done rising edge, or the cycle after a bad checksum byte.

Reset
REQ-034 With rst=0 at a clock edge, the following take effect the next cycle, from any state including mid-frame or SEND:
- state=IDLE;
- img_data=0, counter=0, sum=0, gap counter=0, previous-done register=0;
- accel_start=0, tx_valid=0, tx_data=0, busy=0, frame_err=0.
REQ-035 While rst=0, rx_valid and accel_done are ignored.

Verification
REQ-036 Good frame: A5, 784×01, checksum 10 -> one-cycle accel_start the cycle after 10; img_data all 8'h01; pred_digit=6 with accel_done rising -> tx_data=8'h36, tx_valid held until tx_ready; then busy=0.
REQ-037 Bad checksum: A5, 784×01, checksum 11 -> no accel_start; tx_data=8'hEE; frame_err=1; IDLE after the handshake.
REQ-038 Timeout (TIMEOUT_CYC=100): A5, 10 bytes, then silence -> IDLE 100 cycles after the last byte; frame_err=1; tx_valid never asserted; a following good frame is accepted.
REQ-039 Garbage and embedded sync: bytes 00 FF 13 before A5 ignored; a pixel value A5 at index 5 stored as a pixel; checksum computed over it -> accepted.
REQ-040 Stale done and ignored traffic: accel_done held 1 entering WAIT_DONE -> no response until it falls and rises; rx_valid bytes during WAIT_DONE leave img_data unchanged.
REQ-041 Reset mid-frame: rst=0 after 400 pixels -> all outputs zero next cycle; a new complete frame then succeeds.
